// File: rtl/gb_reg_ram_responder_if.sv
// Ghostbus link between one host and one responder.
// Latency: none, wires only; read data returns 2 edges after the address.
// Backpressure: none, the host owns the timing and the responder always keeps up.
//
// Signals:
//   gb_addr  host -> responder  word address
//   gb_dout  host -> responder  write data
//   gb_we    host -> responder  write enable, sampled at posedge clk
//   gb_din   responder -> host  read data, zero when the responder is not addressed
interface gb_reg_ram_responder_if #(
    parameter int GB_AW = 12,
    parameter int GB_DW = 32
);
    logic [GB_AW-1:0] gb_addr;
    logic [GB_DW-1:0] gb_dout;
    logic             gb_we;
    logic [GB_DW-1:0] gb_din;

    modport master (
        output gb_addr,
        output gb_dout,
        output gb_we,
        input  gb_din
    );

    modport slave (
        input  gb_addr,
        input  gb_dout,
        input  gb_we,
        output gb_din
    );
endinterface

// File: rtl/gb_reg_ram_responder.sv
// Ghostbus responder: control registers, saturating event counter, ID word and a dual-port RAM.
// Latency: bus read data 2 edges after the address, writes 1 edge; user RAM read 1 edge.
// Backpressure: none; one access per cycle is always accepted, and gb_din is zero outside the window.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   gb              ghostbus slave (gb_addr, gb_dout, gb_we in; gb_din out)
//   ctrl_out        control registers, reg k at [k*GB_DW +: GB_DW]
//   event_in        single-cycle pulse counted by the event counter
//   usr_raddr/rdata user-side RAM read port, registered
//   wr_err          sticky bad-write flag, present only when GB_RESP_WRERR_EN is defined
//
// Local map (word offsets from BASE):
//   0x000..NREG-1   control registers, RW
//   0x010           event counter, any write clears
//   0x011           ID word, RO
//   0x012           error register (GB_RESP_WRERR_EN), else reads 0
//   0x100..         RAM, 2^RAM_AW words, read-first
//   elsewhere       reads 0, writes ignored
//
// Optional feature macro: GB_RESP_WRERR_EN.
module gb_reg_ram_responder #(
    parameter int               GB_AW  = 12,
    parameter int               GB_DW  = 32,
    parameter logic [GB_AW-1:0] BASE   = 12'h200,
    parameter int               WIN_AW = 9,
    parameter int               NREG   = 4,
    parameter int               RAM_AW = 6,
    parameter int               CW     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    gb_reg_ram_responder_if.slave    gb,
    output logic [NREG*GB_DW-1:0]    ctrl_out,
    input  logic                     event_in,
    input  logic [RAM_AW-1:0]        usr_raddr,
    output logic [GB_DW-1:0]         usr_rdata
`ifdef GB_RESP_WRERR_EN
    ,
    output logic                     wr_err
`endif
);

    localparam logic [WIN_AW-1:0] OFF_CNT  = WIN_AW'(12'h010);
    localparam logic [WIN_AW-1:0] OFF_ID   = WIN_AW'(12'h011);
    localparam logic [WIN_AW-1:0] OFF_ERR  = WIN_AW'(12'h012);
    localparam logic [GB_DW-1:0]  ID_WORD  = GB_DW'(32'h6762_7231);
    localparam logic [CW-1:0]     CNT_MAX  = {CW{1'b1}};

    // The RAM sits at offset 0x100; since RAM_AW <= 8 that base is aligned to the
    // RAM size, so the region is simply one "page" of the offset's upper bits.
    localparam int                PAGE_W   = WIN_AW - RAM_AW;
    localparam logic [PAGE_W-1:0] RAM_PAGE = PAGE_W'(256 >> RAM_AW);

    // Offset class carried from stage 1 to stage 2.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_REG,
        SEL_RAM
    } sel_e;

    // Stage-1 read state. Register-type data is captured here so a write on the
    // edge before stage 1 is visible, while the RAM data comes from its own port.
    typedef struct packed {
        logic             hit;
        sel_e             sel;
        logic [GB_DW-1:0] dat;
    } s1_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic              hit;
    logic [WIN_AW-1:0] off;
    logic              ram_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr;
    logic              cnt_clr;

    assign hit     = (gb.gb_addr[GB_AW-1:WIN_AW] == BASE[GB_AW-1:WIN_AW]);
    assign off     = gb.gb_addr[WIN_AW-1:0];
    assign ram_idx = off[RAM_AW-1:0];
    assign ram_hit = (off[WIN_AW-1:RAM_AW] == RAM_PAGE);
    assign wr      = hit & gb.gb_we;
    assign cnt_clr = wr && (off == OFF_CNT);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [GB_DW-1:0] ctrl_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                ctrl_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (wr && (off == WIN_AW'(k))) begin
                    ctrl_q[k] <= gb.gb_dout;
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_ctrl_out
        assign ctrl_out[g*GB_DW +: GB_DW] = ctrl_q[g];
    end

    // ------------------------------------------------------------------
    // Event counter: saturating, write-to-clear. A clear and an event on the
    // same edge leave exactly that one event counted.
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= event_in ? CW'(1) : '0;
        end else if (event_in && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Error register
    // ------------------------------------------------------------------
    logic [GB_DW-1:0] err_word;

`ifdef GB_RESP_WRERR_EN
    logic             err_flag_q;
    logic [GB_AW-1:0] err_addr_q;
    logic             wr_mapped;
    logic             bad_wr;
    logic             err_clr;

    // Writable offsets; everything else in the window (ID included) is a bad write.
    // The error register itself is writable so clearing it never flags an error.
    always_comb begin
        wr_mapped = ram_hit || (off == OFF_CNT) || (off == OFF_ERR);
        for (int k = 0; k < NREG; k++) begin
            if (off == WIN_AW'(k)) begin
                wr_mapped = 1'b1;
            end
        end
    end

    assign bad_wr  = wr && !wr_mapped;
    assign err_clr = wr && (off == OFF_ERR) && gb.gb_dout[0];

    // Only the first offending address is kept; a clear on the same edge as a
    // new error lets the new error win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (err_clr) begin
                err_flag_q <= 1'b0;
                err_addr_q <= '0;
            end
            if (bad_wr && (!err_flag_q || err_clr)) begin
                err_flag_q <= 1'b1;
                err_addr_q <= gb.gb_addr;
            end
        end
    end

    assign wr_err = err_flag_q;

    always_comb begin
        err_word                = '0;
        err_word[0]             = err_flag_q;
        err_word[16 +: GB_AW]   = err_addr_q;
    end
`else
    assign err_word = '0;
`endif

    // ------------------------------------------------------------------
    // Dual-port RAM: bus read/write port plus user read port. Both reads are
    // read-first against a same-edge bus write. Contents are not reset.
    // ------------------------------------------------------------------
    logic [GB_DW-1:0] mem [2**RAM_AW];
    logic [GB_DW-1:0] ram_q;

    always_ff @(posedge clk) begin
        if (wr && ram_hit) begin
            mem[ram_idx] <= gb.gb_dout;
        end
        ram_q <= mem[ram_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            usr_rdata <= '0;
        end else begin
            usr_rdata <= mem[usr_raddr];
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    s1_t s1_d;
    s1_t s1_q;

    always_comb begin
        s1_d.hit = hit;
        s1_d.sel = SEL_NONE;
        s1_d.dat = '0;
        if (hit) begin
            if (ram_hit) begin
                s1_d.sel = SEL_RAM;
            end else if (off == OFF_CNT) begin
                s1_d.sel = SEL_REG;
                s1_d.dat = GB_DW'(cnt_q);
            end else if (off == OFF_ID) begin
                s1_d.sel = SEL_REG;
                s1_d.dat = ID_WORD;
            end else if (off == OFF_ERR) begin
                s1_d.sel = SEL_REG;
                s1_d.dat = err_word;
            end else begin
                for (int k = 0; k < NREG; k++) begin
                    if (off == WIN_AW'(k)) begin
                        s1_d.sel = SEL_REG;
                        s1_d.dat = ctrl_q[k];
                    end
                end
            end
        end
    end

    // Stage 2 forces zero on a miss so parent levels can OR responders together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            gb.gb_din <= '0;
        end else begin
            s1_q <= s1_d;
            if (!s1_q.hit) begin
                gb.gb_din <= '0;
            end else begin
                case (s1_q.sel)
                    SEL_REG: gb.gb_din <= s1_q.dat;
                    SEL_RAM: gb.gb_din <= ram_q;
                    default: gb.gb_din <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gb_reg_ram_responder.sv
// Testbench for gb_reg_ram_responder.
// Latency: bus reads are scored 2 edges after the address, user reads 1 edge.
// Backpressure: none; the bench drives one bus access per cycle.
module tb_gb_reg_ram_responder;

    localparam int          GB_AW  = 12;
    localparam int          GB_DW  = 32;
    localparam int          NREG   = 4;
    localparam int          RAM_AW = 6;
    localparam logic [31:0] ID     = 32'h6762_7231;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    event_in = 1'b0;
    logic [RAM_AW-1:0]       usr_raddr = '0;
    logic [GB_DW-1:0]        usr_rdata;
    logic [NREG*GB_DW-1:0]   ctrl_out;
`ifdef GB_RESP_WRERR_EN
    logic                    wr_err;
`endif

    gb_reg_ram_responder_if #(.GB_AW(GB_AW), .GB_DW(GB_DW)) gb ();

    gb_reg_ram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .gb        (gb),
        .ctrl_out  (ctrl_out),
        .event_in  (event_in),
        .usr_raddr (usr_raddr),
        .usr_rdata (usr_rdata)
`ifdef GB_RESP_WRERR_EN
        ,
        .wr_err    (wr_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entry: gb_din expected at the negedge where cyc == due.
    typedef struct {
        int          due;
        logic [31:0] exp;
        logic [11:0] addr;
    } sb_t;

    typedef struct {
        logic [11:0] a;
        logic        we;
        logic [31:0] d;
        logic        ev;
        logic        chk;
        logic [31:0] exp;
    } op_t;

    sb_t         sb[$];
    logic [31:0] ctrl_m [NREG];

    function automatic logic [NREG*GB_DW-1:0] ctrl_model();
        logic [NREG*GB_DW-1:0] v;
        for (int k = 0; k < NREG; k++) v[k*GB_DW +: GB_DW] = ctrl_m[k];
        return v;
    endfunction

    // One bus cycle starting at a negedge: drive, optionally queue the read
    // expectation, advance to the next negedge and go idle.
    task automatic drive(input logic [11:0] a, input logic we, input logic [31:0] d,
                         input logic ev, input logic chk, input logic [31:0] exp);
        gb.gb_addr = a;
        gb.gb_dout = d;
        gb.gb_we   = we;
        event_in   = ev;
        if (chk) sb.push_back('{cyc + 2, exp, a});
        if (we && !rst && a >= 12'h200 && a < 12'h200 + NREG) ctrl_m[a - 12'h200] = d;
        @(negedge clk);
        gb.gb_we = 1'b0;
        event_in = 1'b0;
    endtask

    task automatic test_reset();
        op_t ops[$];
        sb_t e;
        rst = 1'b1;
        for (int k = 0; k < NREG; k++) ctrl_m[k] = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (gb.gb_din !== 32'h0) begin n_bad++; $display("FAIL rst_din: got %h want 0", gb.gb_din); end
        n_cmp++; if (ctrl_out !== '0) begin n_bad++; $display("FAIL rst_ctrl: got %h want 0", ctrl_out); end
        n_cmp++; if (usr_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_usr: got %h want 0", usr_rdata); end
`ifdef GB_RESP_WRERR_EN
        n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("FAIL rst_wr_err: got %b want 0", wr_err); end
`endif
        rst = 1'b0;
        ops.push_back('{12'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h201, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h202, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h203, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h211, 1'b0, 32'h0, 1'b0, 1'b1, ID});
        ops.push_back('{12'h212, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        for (int i = 0; i < ops.size() + 2; i++) begin
            if (i < ops.size()) drive(ops[i].a, ops[i].we, ops[i].d, ops[i].ev, ops[i].chk, ops[i].exp);
            else drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (gb.gb_din !== e.exp) begin n_bad++; $display("FAIL reset_rd_%h: got %h want %h", e.addr, gb.gb_din, e.exp); end
            end
        end
    endtask

    task automatic test_ctrl();
        op_t ops[$];
        sb_t e;
        drive(12'h201, 1'b1, 32'hdadb00b5, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (ctrl_out[63:32] !== 32'hdadb00b5) begin n_bad++; $display("FAIL ctrl1_next: got %h want dadb00b5", ctrl_out[63:32]); end
        n_cmp++; if (ctrl_out[31:0] !== 32'h0) begin n_bad++; $display("FAIL ctrl0_kept: got %h want 0", ctrl_out[31:0]); end
        ops.push_back('{12'h201, 1'b0, 32'h0, 1'b0, 1'b1, 32'hdadb00b5});
        ops.push_back('{12'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h203, 1'b1, 32'h000000f3, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h203, 1'b0, 32'h0, 1'b0, 1'b1, 32'h000000f3});
        ops.push_back('{12'h204, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        for (int i = 0; i < ops.size() + 2; i++) begin
            if (i < ops.size()) drive(ops[i].a, ops[i].we, ops[i].d, ops[i].ev, ops[i].chk, ops[i].exp);
            else drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (gb.gb_din !== e.exp) begin n_bad++; $display("FAIL ctrl_rd_%h: got %h want %h", e.addr, gb.gb_din, e.exp); end
            end
        end
        n_cmp++; if (ctrl_out !== ctrl_model()) begin n_bad++; $display("FAIL ctrl_all: got %h want %h", ctrl_out, ctrl_model()); end
    endtask

    task automatic test_ram();
        op_t ops[$];
        sb_t e;
        usr_raddr = 6'd5;
        drive(12'h305, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0);
        drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (usr_rdata !== 32'h12345678) begin n_bad++; $display("FAIL usr_rd5: got %h want 12345678", usr_rdata); end
        drive(12'h305, 1'b1, 32'h0badf00d, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (usr_rdata !== 32'h12345678) begin n_bad++; $display("FAIL usr_rdw_old: got %h want 12345678", usr_rdata); end
        drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (usr_rdata !== 32'h0badf00d) begin n_bad++; $display("FAIL usr_rd5_new: got %h want 0badf00d", usr_rdata); end
        ops.push_back('{12'h304, 1'b1, 32'hcafef00d, 1'b0, 1'b0, 32'h0});
        ops.push_back('{12'h305, 1'b1, 32'h12345678, 1'b0, 1'b1, 32'h0badf00d});
        ops.push_back('{12'h304, 1'b0, 32'h0, 1'b0, 1'b1, 32'hcafef00d});
        ops.push_back('{12'h305, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678});
        ops.push_back('{12'h304, 1'b0, 32'h0, 1'b0, 1'b1, 32'hcafef00d});
        ops.push_back('{12'h305, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678});
        ops.push_back('{12'h33f, 1'b1, 32'h5a5a0033, 1'b0, 1'b0, 32'h0});
        ops.push_back('{12'h33f, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5a5a0033});
        ops.push_back('{12'h340, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h211, 1'b0, 32'h0, 1'b0, 1'b1, ID});
        for (int i = 0; i < ops.size() + 2; i++) begin
            if (i < ops.size()) drive(ops[i].a, ops[i].we, ops[i].d, ops[i].ev, ops[i].chk, ops[i].exp);
            else drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (gb.gb_din !== e.exp) begin n_bad++; $display("FAIL ram_rd_%h: got %h want %h", e.addr, gb.gb_din, e.exp); end
            end
        end
    endtask

    task automatic test_out_of_window();
        op_t ops[$];
        sb_t e;
        ops.push_back('{12'h400, 1'b1, 32'hffffffff, 1'b0, 1'b0, 32'h0});
        ops.push_back('{12'h400, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h201, 1'b0, 32'h0, 1'b0, 1'b1, 32'hdadb00b5});
        ops.push_back('{12'h504, 1'b1, 32'hffffffff, 1'b0, 1'b0, 32'h0});
        ops.push_back('{12'h304, 1'b0, 32'h0, 1'b0, 1'b1, 32'hcafef00d});
        ops.push_back('{12'h600, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        for (int i = 0; i < ops.size() + 2; i++) begin
            if (i < ops.size()) drive(ops[i].a, ops[i].we, ops[i].d, ops[i].ev, ops[i].chk, ops[i].exp);
            else drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (gb.gb_din !== e.exp) begin n_bad++; $display("FAIL oow_rd_%h: got %h want %h", e.addr, gb.gb_din, e.exp); end
            end
        end
        n_cmp++; if (ctrl_out !== ctrl_model()) begin n_bad++; $display("FAIL oow_ctrl: got %h want %h", ctrl_out, ctrl_model()); end
    endtask

    task automatic test_counter();
        op_t ops[$];
        sb_t e;
        repeat (3) ops.push_back('{12'h000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0});
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b0, 1'b1, 32'd3});
        ops.push_back('{12'h210, 1'b1, 32'h0, 1'b1, 1'b1, 32'd3});
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b0, 1'b1, 32'd1});
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b1, 1'b1, 32'd1});
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b0, 1'b1, 32'd2});
        ops.push_back('{12'h210, 1'b1, 32'h0, 1'b0, 1'b1, 32'd2});
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0});
        for (int i = 0; i < ops.size() + 2; i++) begin
            if (i < ops.size()) drive(ops[i].a, ops[i].we, ops[i].d, ops[i].ev, ops[i].chk, ops[i].exp);
            else drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (gb.gb_din !== e.exp) begin n_bad++; $display("FAIL cnt_rd_%h: got %h want %h", e.addr, gb.gb_din, e.exp); end
            end
        end
        // Drive the counter past full scale; it must pin at 0xffff.
        event_in = 1'b1;
        repeat (65540) @(negedge clk);
        event_in = 1'b0;
        ops.delete();
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000ffff});
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000ffff});
        ops.push_back('{12'h210, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0000ffff});
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b0, 1'b1, 32'd1});
        for (int i = 0; i < ops.size() + 2; i++) begin
            if (i < ops.size()) drive(ops[i].a, ops[i].we, ops[i].d, ops[i].ev, ops[i].chk, ops[i].exp);
            else drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (gb.gb_din !== e.exp) begin n_bad++; $display("FAIL sat_rd_%h: got %h want %h", e.addr, gb.gb_din, e.exp); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        op_t ops[$];
        sb_t e;
        repeat (3) drive(12'h201, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (gb.gb_din !== 32'hdadb00b5) begin n_bad++; $display("FAIL pre_rst_din: got %h want dadb00b5", gb.gb_din); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (gb.gb_din !== 32'h0) begin n_bad++; $display("FAIL mid_rst_din: got %h want 0", gb.gb_din); end
        n_cmp++; if (ctrl_out !== '0) begin n_bad++; $display("FAIL mid_rst_ctrl: got %h want 0", ctrl_out); end
        for (int k = 0; k < NREG; k++) ctrl_m[k] = '0;
        repeat (2) @(negedge clk);
        gb.gb_addr = 12'h211;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (gb.gb_din !== 32'h0) begin n_bad++; $display("FAIL post_rst_edge1: got %h want 0", gb.gb_din); end
        @(negedge clk);
        n_cmp++; if (gb.gb_din !== ID) begin n_bad++; $display("FAIL post_rst_edge2: got %h want %h", gb.gb_din, ID); end
        ops.push_back('{12'h210, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h305, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678});
        ops.push_back('{12'h201, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        for (int i = 0; i < ops.size() + 2; i++) begin
            if (i < ops.size()) drive(ops[i].a, ops[i].we, ops[i].d, ops[i].ev, ops[i].chk, ops[i].exp);
            else drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (gb.gb_din !== e.exp) begin n_bad++; $display("FAIL rstmid_rd_%h: got %h want %h", e.addr, gb.gb_din, e.exp); end
            end
        end
    endtask

    task automatic test_wrerr();
        op_t ops[$];
        sb_t e;
`ifdef GB_RESP_WRERR_EN
        drive(12'h211, 1'b1, 32'hffffffff, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (wr_err !== 1'b1) begin n_bad++; $display("FAIL wr_err_set: got %b want 1", wr_err); end
        ops.push_back('{12'h212, 1'b0, 32'h0, 1'b0, 1'b1, 32'h02110001});
        ops.push_back('{12'h2f0, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0});
        ops.push_back('{12'h212, 1'b0, 32'h0, 1'b0, 1'b1, 32'h02110001});
        ops.push_back('{12'h212, 1'b1, 32'h1, 1'b0, 1'b1, 32'h02110001});
        ops.push_back('{12'h212, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
        ops.push_back('{12'h212, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0});
        ops.push_back('{12'h212, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
`else
        ops.push_back('{12'h211, 1'b1, 32'hffffffff, 1'b0, 1'b0, 32'h0});
        ops.push_back('{12'h211, 1'b0, 32'h0, 1'b0, 1'b1, ID});
        ops.push_back('{12'h212, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
`endif
        for (int i = 0; i < ops.size() + 2; i++) begin
            if (i < ops.size()) drive(ops[i].a, ops[i].we, ops[i].d, ops[i].ev, ops[i].chk, ops[i].exp);
            else drive(12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (gb.gb_din !== e.exp) begin n_bad++; $display("FAIL err_rd_%h: got %h want %h", e.addr, gb.gb_din, e.exp); end
            end
        end
`ifdef GB_RESP_WRERR_EN
        n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("FAIL wr_err_clr: got %b want 0", wr_err); end
`endif
    endtask

    initial begin
        gb.gb_addr = '0;
        gb.gb_dout = '0;
        gb.gb_we   = 1'b0;
        test_reset();
        test_ctrl();
        test_ram();
        test_out_of_window();
        test_counter();
        test_reset_mid_read();
        test_wrerr();
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_drain: %0d reads left unscored, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gb_reg_ram_responder.md
Name: gb_reg_ram_responder

Overview:
- Ghostbus responder: the target end of the host-driven ghostbus (`gb_addr`/`gb_dout`/`gb_we` in, `gb_din` out).
- Decodes an aligned address window and exposes NREG read/write control registers, a saturating event counter with write-to-clear, and a dual-port RAM.
- The RAM has a second, user-side read port for fabric logic.
- Read data returns with a fixed 2-cycle latency, matching the host read delay. Outside the window, `gb_din` is driven to zero so parent levels can OR-combine responders.

Parameters:
- GB_AW, 12, ghostbus address width
- GB_DW, 32, ghostbus data width
- BASE, 12'h200, window base; must be aligned to 2^WIN_AW
- WIN_AW, 9, window size is 2^WIN_AW words
- NREG, 4, number of control registers (1..16)
- RAM_AW, 6, RAM depth 2^RAM_AW words (RAM_AW <= WIN_AW-1)
- CW, 16, event counter width (CW <= GB_DW)

Ports:
- clk, in, 1, single clock for bus and user side
- rst, in, 1, asynchronous active-high reset
- gb_addr, in, GB_AW, bus address
- gb_dout, in, GB_DW, host write data
- gb_we, in, 1, write enable, sampled at posedge clk
- gb_din, out, GB_DW, read data to host
- ctrl_out, out, NREG*GB_DW, control registers; reg k is at bits [k*GB_DW +: GB_DW]
- event_in, in, 1, single-cycle event pulse to count
- usr_raddr, in, RAM_AW, user RAM read address
- usr_rdata, out, GB_DW, user RAM read data

Behaviour:
- Decode:
  - hit = (gb_addr[GB_AW-1:WIN_AW] == BASE[GB_AW-1:WIN_AW]).
  - off = gb_addr[WIN_AW-1:0].
- Local map (offset from BASE):
  - 0x000..NREG-1: ctrl registers, RW.
  - 0x010: event counter. Read returns count zero-extended. Any write clears it.
  - 0x011: ID, RO, constant 32'h6762_7231.
  - 0x100..0x100+2^RAM_AW-1: RAM, RW.
  - All other offsets: read 0, writes ignored.
- Write:
  - Takes effect when hit && gb_we at a posedge; one write per cycle.
  - ctrl_out reflects the new value on the cycle after the edge.
- Read:
  - Cycle 0: address presented.
  - Edge 1: register hit, offset-class select, RAM read data.
  - Edge 2: gb_din registered.
  - gb_din is therefore valid 2 edges after the address is presented. It follows the address every cycle; there is no read strobe and no side effects on read.
  - Stage-2 value is 0 when the stage-1 hit was 0 or the offset is unmapped.
- Read-during-write to the same RAM address: the host read returns the old data (read-first). Ctrl/counter reads return the post-write value if the write edge precedes stage 1.
- Event counter:
  - Increments on event_in and saturates at 2^CW-1 (no wrap).
  - If a clear write and event_in occur in the same cycle, the result is 1.
- User port: usr_rdata is registered with 1-cycle latency. Same-edge user read and bus write to the same address returns old data.
- Reset (async, rst=1): ctrl regs = 0, counter = 0, both pipeline stages = 0, gb_din = 0, usr_rdata = 0. RAM contents are not reset.
- Reset mid-read: pipeline is flushed, and gb_din stays 0 until 2 edges after rst deasserts with a valid address present.

Optional Feature:
- Macro: GB_RESP_WRERR_EN.
- Defined:
  - Adds sticky `wr_err` output (1 bit) and error register at offset 0x012.
  - Bit0 is set by a write to a RO or unmapped in-window offset (0x011, 0x012 excluded, or gaps).
  - Bits[GB_AW+15:16] capture the first offending full address.
  - Writing 1 to bit0 at 0x012 clears both fields. A new error on the clearing cycle re-sets the flag.
  - Reset clears all of it.
- Not defined: no port, 0x012 reads 0, bad writes are silently ignored.

Test Plan:
- After reset, read 0x200..0x203 and 0x210 -> each gb_din = 0 two edges after the address; read 0x211 -> 0x67627231.
- Write 0x201 = 0xdadb00b5 -> ctrl_out[63:32] = 0xdadb00b5 the next cycle; read 0x201 -> 0xdadb00b5 at latency 2; ctrl0 is unchanged.
- Write 0x305 = 0x12345678 -> usr_raddr=5 gives usr_rdata = 0x12345678 one cycle later; bus read 0x305 matches; back-to-back reads of 0x304/0x305 pipeline correctly.
- Write 0x400 = 0xffffffff and read 0x400 -> gb_din = 0 and no in-window state changes.
- 3 event_in pulses -> read 0x210 = 3. Write 0x210 in the same cycle as a pulse -> then reads 1. Force 0xFFFF plus more pulses -> stays 0xFFFF.
- Assert rst mid-read of 0x201 -> gb_din = 0 immediately and ctrl_out = 0. With GB_RESP_WRERR_EN, write 0x211 -> wr_err = 1 and 0x212 reads 0x02110001; writing 1 to 0x212 clears it.
